tone_envelope: RTL and testbench
================================

TONE_ENVELOPE -- requirements
Module: tone_envelope

Interface
REQ-001 Parameter TICK_DIV, 24'd9600: clock cycles per envelope tick; 0 is treated as 1.
REQ-002 Parameter ATTACK_STEP, 8'd16: level increment per tick in ATTACK.
REQ-003 Parameter DECAY_STEP, 8'd4: level decrement per tick in DECAY.
REQ-004 Parameter SUSTAIN_LVL, 8'd160: level held in SUSTAIN.
REQ-005 Parameter RELEASE_STEP, 8'd2: level decrement per tick in RELEASE.
REQ-006 Port clk, input, 1 bit: the block's only clock; all logic on its rising edge.
REQ-007 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 Port tone_i, input, 1 bit: square wave from the upstream PWM tone generator.
REQ-009 Port note_strb_i, input, 1 bit: one-cycle pulse marking a new sequencer note.
REQ-010 Port gate_i, input, 1 bit: sampled with note_strb_i; 1 = note, 0 = rest.
REQ-011 Port sound_o, output, 1 bit: enveloped audio to the pin.
REQ-012 Port level_o, output, 8 bits: current envelope level.
REQ-013 Port state_o, output, 3 bits: encoded FSM state.
REQ-014 Port busy_o, output, 1 bit: high in any state except IDLE.

Function
REQ-015 Tick counter SHALL count 0..TICK_DIV-1 freely; tick is high for the one cycle the count equals TICK_DIV-1.
REQ-016 FSM states and encodings SHALL be IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
REQ-017 On note_strb_i with gate_i=1, any state SHALL go to ATTACK, keeping level_o (retrigger without a reset to 0).
REQ-018 On note_strb_i with gate_i=0, ATTACK/DECAY/SUSTAIN SHALL go to RELEASE; IDLE SHALL stay in IDLE; RELEASE SHALL stay in RELEASE.
REQ-019 In ATTACK, on each tick, level SHALL become min(level+ATTACK_STEP, 255), using a 9-bit sum; on reaching 255 the state SHALL go to DECAY.
REQ-020 In DECAY, on each tick: if level-DECAY_STEP <= SUSTAIN_LVL (signed compare, no underflow), level SHALL become SUSTAIN_LVL and the state SHALL go to SUSTAIN; otherwise level SHALL be decremented by DECAY_STEP.
REQ-021 SUSTAIN SHALL hold level until a strobe arrives.
REQ-022 In RELEASE, on each tick, level SHALL become max(level-RELEASE_STEP, 0); on reaching 0 the state SHALL go to IDLE.
REQ-023 When a strobe and a tick occur in the same cycle, the strobe SHALL take priority: state changes per REQ-017/018 and level is not updated that cycle.
REQ-024 Amplitude PWM: an 8-bit counter SHALL count 0..254 and wrap; amp = (counter < level_o).
REQ-025 sound_o SHALL be registered tone_i AND amp; this gives one cycle of latency from tone_i.
REQ-026 Level 255 SHALL pass tone_i unchanged (delayed one cycle); level 0 SHALL force sound_o to 0.

Reset
REQ-027 While rst_n=0 at a clock edge, the block SHALL reset to: state IDLE, level_o=0, sound_o=0, busy_o=0, tick counter=0, amplitude counter=0.
REQ-028 Reset mid-envelope SHALL abort immediately, with no release tail.
REQ-029 A strobe coincident with reset SHALL be ignored.

Structure
REQ-030 State encodings and the 8-bit level width SHALL live in shared package tinytone_pkg.
REQ-031 The tick divider SHALL be a separate sub-module, env_tick_gen (inputs clk, rst_n; parameter TICK_DIV; output tick_o).
REQ-032 Implementation target: a single FSM plus datapath of about 150-250 lines.

Verification (TICK_DIV=4, default steps)
REQ-033 Attack from IDLE: strobe with gate_i=1 -> ATTACK; level_o = 16, 32, ... each tick; level_o = 255 on tick 16; state goes to DECAY.
REQ-034 Decay: from 255, level_o drops by 4 per tick; on tick 24, level_o clamps to 160 and state goes to SUSTAIN; the level then holds for 1000 cycles.
REQ-035 Release: strobe with gate_i=0 in SUSTAIN -> RELEASE; level_o reaches 0 after 80 ticks; state goes to IDLE and busy_o falls.
REQ-036 Retrigger: strobe with gate_i=1 at level 100 in RELEASE -> ATTACK; the next tick gives 116; a strobe coinciding with a tick leaves level unchanged that cycle.
REQ-037 Output gating: with tone_i held at 1 and level_o at 160, sound_o is high for 160 of every 255 cycles; with level 0, sound_o is 0.
REQ-038 Reset mid-DECAY: rst_n low for 1 cycle -> next cycle shows IDLE, level_o=0, sound_o=0.

Source files
------------

// File: rtl/tinytone_pkg.sv
// Shared types for the tiny-tone voice: envelope FSM encodings and level width.
package tinytone_pkg;

    localparam int LEVEL_W = 8;

    typedef logic [LEVEL_W-1:0] level_t;

    localparam level_t LEVEL_MAX = 8'hFF;
    localparam level_t LEVEL_MIN = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

endpackage

// File: rtl/env_tick_gen.sv
// Free-running divider producing a one-cycle envelope tick every TICK_DIV clocks.
module env_tick_gen #(
    parameter logic [23:0] TICK_DIV = 24'd9600
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    // A divide-by-zero request behaves as divide-by-one (tick every cycle).
    localparam logic [23:0] DIV_EFF = (TICK_DIV == 24'd0) ? 24'd1 : TICK_DIV;
    localparam logic [23:0] LAST    = DIV_EFF - 24'd1;

    logic [23:0] count;

    assign tick_o = (count == LAST);

    // Count 0..DIV_EFF-1 and wrap on the tick cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 24'd0;
        end else if (tick_o) begin
            count <= 24'd0;
        end else begin
            count <= count + 24'd1;
        end
    end

endmodule

// File: rtl/tone_envelope.sv
// ADSR-style envelope that amplitude-modulates a square tone with a PWM gate.
module tone_envelope
    import tinytone_pkg::*;
#(
    parameter logic [23:0] TICK_DIV     = 24'd9600,
    parameter logic [7:0]  ATTACK_STEP  = 8'd16,
    parameter logic [7:0]  DECAY_STEP   = 8'd4,
    parameter logic [7:0]  SUSTAIN_LVL  = 8'd160,
    parameter logic [7:0]  RELEASE_STEP = 8'd2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tone_i,
    input  logic       note_strb_i,
    input  logic       gate_i,
    output logic       sound_o,
    output logic [7:0] level_o,
    output logic [2:0] state_o,
    output logic       busy_o
);

    env_state_t state, next_state;
    level_t     level, next_level;
    logic       tick;
    logic [7:0] amp_cnt;
    logic       amp;
    logic       sound_p1;
    logic signed [LEVEL_W+1:0] decay_diff;
    logic signed [LEVEL_W+1:0] release_diff;

    // Saturating add through a 9-bit sum so the level never wraps past 255.
    function automatic level_t add_sat(input level_t a, input logic [7:0] b);
        logic [LEVEL_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum >= {1'b0, LEVEL_MAX}) ? LEVEL_MAX : sum[LEVEL_W-1:0];
    endfunction

    // Two's-complement difference wide enough to go negative without wrapping.
    function automatic logic signed [LEVEL_W+1:0] sub_signed(input level_t a,
                                                             input logic [7:0] b);
        return $signed({2'b00, a}) - $signed({2'b00, b});
    endfunction

    env_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    // Envelope state and level registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            level <= LEVEL_MIN;
        end else begin
            state <= next_state;
            level <= next_level;
        end
    end

    // Next-state logic: a strobe pre-empts any tick-driven level update.
    always_comb begin
        next_state   = state;
        next_level   = level;
        decay_diff   = sub_signed(level, DECAY_STEP);
        release_diff = sub_signed(level, RELEASE_STEP);
        if (note_strb_i) begin
            if (gate_i) begin
                next_state = ST_ATTACK;
            end else if (state == ST_ATTACK || state == ST_DECAY || state == ST_SUSTAIN) begin
                next_state = ST_RELEASE;
            end
        end else if (tick) begin
            case (state)
                ST_ATTACK: begin
                    next_level = add_sat(level, ATTACK_STEP);
                    if (next_level == LEVEL_MAX) next_state = ST_DECAY;
                end
                ST_DECAY: begin
                    if (decay_diff <= $signed({2'b00, SUSTAIN_LVL})) begin
                        next_level = SUSTAIN_LVL;
                        next_state = ST_SUSTAIN;
                    end else begin
                        next_level = decay_diff[LEVEL_W-1:0];
                    end
                end
                ST_RELEASE: begin
                    if (release_diff <= 0) begin
                        next_level = LEVEL_MIN;
                        next_state = ST_IDLE;
                    end else begin
                        next_level = release_diff[LEVEL_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Amplitude PWM carrier: 0..254 so level 255 is always on.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            amp_cnt <= 8'd0;
        end else if (amp_cnt == 8'd254) begin
            amp_cnt <= 8'd0;
        end else begin
            amp_cnt <= amp_cnt + 8'd1;
        end
    end

    assign amp = (amp_cnt < level);

    // Output register: tone gated by amplitude, one cycle behind tone_i.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sound_p1 <= 1'b0;
        end else begin
            sound_p1 <= tone_i & amp;
        end
    end

    assign sound_o = sound_p1;
    assign level_o = level;
    assign state_o = state;
    assign busy_o  = (state != ST_IDLE);

endmodule

// File: tb/tb_tone_envelope.sv
// Directed bench for tone_envelope with a short tick period.
module tb_tone_envelope;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tone_i;
    logic       note_strb_i;
    logic       gate_i;
    logic       sound_o;
    logic [7:0] level_o;
    logic [2:0] state_o;
    logic       busy_o;

    int total = 0;
    int bad   = 0;
    int wait_n;
    int highs;
    int hold_bad;

    tone_envelope #(
        .TICK_DIV     (24'd4),
        .ATTACK_STEP  (8'd16),
        .DECAY_STEP   (8'd4),
        .SUSTAIN_LVL  (8'd160),
        .RELEASE_STEP (8'd2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tone_i      (tone_i),
        .note_strb_i (note_strb_i),
        .gate_i      (gate_i),
        .sound_o     (sound_o),
        .level_o     (level_o),
        .state_o     (state_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Step until level_o changes (bounded); n = cycles taken, -1 on timeout.
    task automatic wait_change(output int n);
        logic [7:0] prev;
        prev = level_o;
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (level_o !== prev) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic tick_chk(input string tag, input int exp);
        wait_change(wait_n);
        chk(tag, level_o, exp);
    endtask

    task automatic strobe(input logic g);
        note_strb_i = 1'b1;
        gate_i      = g;
        step();
        note_strb_i = 1'b0;
        gate_i      = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; tone_i = 1'b0; note_strb_i = 1'b0; gate_i = 1'b0;
        step(); step(); step();
        chk("rst_state", state_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_sound", sound_o, 0);
        chk("rst_busy", busy_o, 0);
        rst_n = 1'b1;

        // Rest strobe in IDLE stays in IDLE.
        strobe(1'b0);
        chk("idle_rest_state", state_o, 0);

        // Attack from IDLE.
        strobe(1'b1);
        chk("atk_state", state_o, 1);
        chk("atk_busy", busy_o, 1);
        chk("atk_level0", level_o, 0);
        for (int k = 1; k <= 16; k++) begin
            tick_chk("atk_level", (16 * k > 255) ? 255 : 16 * k);
            if (k >= 2) chk("atk_tick_period", wait_n, 4);
        end
        chk("atk_to_decay", state_o, 2);

        // Decay to sustain clamp on tick 24.
        for (int n = 1; n <= 24; n++) begin
            tick_chk("dec_level", (n < 24) ? 255 - 4 * n : 160);
            if (n == 23) chk("dec_state_mid", state_o, 2);
        end
        chk("dec_to_sustain", state_o, 3);

        // Sustain hold and PWM duty with tone held high.
        tone_i = 1'b1;
        hold_bad = 0;
        highs = 0;
        for (int c = 0; c < 1000; c++) begin
            step();
            if (level_o !== 8'd160) hold_bad++;
            if (c < 255 && sound_o === 1'b1) highs++;
        end
        chk("sus_hold", hold_bad, 0);
        chk("sus_duty", highs, 160);
        tone_i = 1'b0;
        step();
        chk("tone_low_sound", sound_o, 0);

        // Release to zero.
        strobe(1'b0);
        chk("rel_state", state_o, 4);
        chk("rel_level0", level_o, 160);
        for (int n = 1; n <= 80; n++) begin
            tick_chk("rel_level", 160 - 2 * n);
        end
        chk("rel_to_idle", state_o, 0);
        chk("rel_busy", busy_o, 0);
        tone_i = 1'b1;
        highs = 0;
        for (int c = 0; c < 255; c++) begin
            step();
            if (sound_o === 1'b1) highs++;
        end
        chk("zero_level_silent", highs, 0);

        // Second envelope, release down to 100, then retrigger.
        strobe(1'b1);
        for (int k = 1; k <= 16; k++) tick_chk("atk2_level", (16 * k > 255) ? 255 : 16 * k);
        for (int n = 1; n <= 24; n++) tick_chk("dec2_level", (n < 24) ? 255 - 4 * n : 160);
        strobe(1'b0);
        for (int n = 1; n <= 30; n++) tick_chk("rel2_level", 160 - 2 * n);
        chk("rel2_state", state_o, 4);
        strobe(1'b1);
        chk("retrig_state", state_o, 1);
        chk("retrig_level", level_o, 100);
        tick_chk("retrig_tick", 116);

        // Strobe coinciding with the next tick: level must not move.
        step(); step(); step();
        strobe(1'b1);
        chk("strb_tick_level", level_o, 116);
        chk("strb_tick_state", state_o, 1);
        tick_chk("after_strb_tick", 132);
        chk("after_strb_period", wait_n, 4);

        // Climb into DECAY, then reset mid-envelope with a coincident strobe.
        for (int k = 1; k <= 8; k++) tick_chk("atk3_level", (132 + 16 * k > 255) ? 255 : 132 + 16 * k);
        tick_chk("dec3_level", 251);
        tick_chk("dec3_level", 247);
        chk("dec3_state", state_o, 2);
        rst_n = 1'b0;
        note_strb_i = 1'b1;
        gate_i = 1'b1;
        step();
        note_strb_i = 1'b0;
        gate_i = 1'b0;
        rst_n = 1'b1;
        chk("midrst_state", state_o, 0);
        chk("midrst_level", level_o, 0);
        chk("midrst_sound", sound_o, 0);
        chk("midrst_busy", busy_o, 0);
        step();
        chk("postrst_state", state_o, 0);
        chk("postrst_level", level_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
